// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the halfword data memory: IDLE -> ACCESS -> RESP.
// Latency: gnt in cycle N, done in cycle N+2; one access per 3 cycles; misaligned accesses never reach memory.
module dmem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int FIXED_PRIO = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              done0,
   output logic              done1,
   output logic [DATA_W-1:0] rdata,
   output logic              err,
   output logic              mem_we_half,
   output logic              mem_re_half,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t state, state_nxt;
   logic   owner;
   logic   lat_we;
   logic   ptr;
   logic   winner;
   logic   any_req;

   always_comb begin
      state_nxt   = state;
      gnt0        = 1'b0;
      gnt1        = 1'b0;
      mem_we_half = 1'b0;
      mem_re_half = 1'b0;
      any_req     = req0 | req1;
      // A lone requester wins outright; the pointer only breaks ties.
      if (req0 && req1)
         winner = (FIXED_PRIO != 0) ? 1'b0 : ptr;
      else
         winner = req1;
      case (state)
         IDLE: begin
            if (any_req && !rst) begin
               gnt0      = ~winner;
               gnt1      = winner;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (!rst && !mem_addr[0]) begin
               mem_we_half = lat_we;
               mem_re_half = ~lat_we;
            end
            state_nxt = RESP;
         end
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         owner     <= 1'b0;
         lat_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         rdata     <= '0;
         err       <= 1'b0;
         done0     <= 1'b0;
         done1     <= 1'b0;
      end else begin
         state <= state_nxt;
         done0 <= 1'b0;
         done1 <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  owner     <= winner;
                  lat_we    <= winner ? we1 : we0;
                  mem_addr  <= winner ? addr1 : addr0;
                  mem_wdata <= winner ? wdata1 : wdata0;
               end
            end
            ACCESS: begin
               err   <= mem_addr[0];
               rdata <= (!lat_we && !mem_addr[0]) ? mem_rdata : '0;
               done0 <= ~owner;
               done1 <= owner;
            end
            RESP:    ptr <= ~owner;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: round-robin instance with a halfword memory model and scoreboard,
// plus a fixed-priority instance checked for grant order only.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;

   // round-robin instance
   logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
   logic [31:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
   logic        gnt0, gnt1, done0, done1, err, mem_we_half, mem_re_half;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;

   // fixed-priority instance
   logic        b_req0 = 0, b_req1 = 0;
   logic        b_we0 = 0, b_we1 = 0;
   logic [31:0] b_addr0 = 0, b_addr1 = 0, b_wdata0 = 0, b_wdata1 = 0, b_mem_rdata = 0;
   logic        b_gnt0, b_gnt1, b_done0, b_done1, b_err, b_mem_we_half, b_mem_re_half;
   logic [31:0] b_rdata, b_mem_addr, b_mem_wdata;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(0)) dut (
      .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata(rdata), .err(err),
      .mem_we_half(mem_we_half), .mem_re_half(mem_re_half), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1)) dut_fp (
      .clk(clk), .rst(rst), .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
      .addr0(b_addr0), .addr1(b_addr1), .wdata0(b_wdata0), .wdata1(b_wdata1),
      .gnt0(b_gnt0), .gnt1(b_gnt1), .done0(b_done0), .done1(b_done1), .rdata(b_rdata), .err(b_err),
      .mem_we_half(b_mem_we_half), .mem_re_half(b_mem_re_half), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // halfword memory with sign-extending combinational read
   logic [15:0] mem [0:255];
   logic [15:0] mem_h;
   initial for (int i = 0; i < 256; i++) mem[i] = 16'h0;
   always @(posedge clk) if (mem_we_half) mem[mem_addr[8:1]] <= mem_wdata[15:0];
   assign mem_h     = mem[mem_addr[8:1]];
   assign mem_rdata = {{16{mem_h[15]}}, mem_h};

   typedef struct {
      logic        port;
      logic [31:0] rdata;
      logic        err;
      int          gcyc;
      int          we_n;
      int          re_n;
   } exp_t;
   exp_t sbq[$];
   exp_t m_e;
   int   we_cnt = 0, re_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic p, input logic w, input logic [31:0] a,
                           input logic [31:0] er, input logic ee);
      exp_t e;
      e.port  = p;
      e.rdata = er;
      e.err   = ee;
      e.gcyc  = cyc;
      e.we_n  = (w && !a[0]) ? 1 : 0;
      e.re_n  = (!w && !a[0]) ? 1 : 0;
      sbq.push_back(e);
   endtask

   // scoreboard: every done pulse must match the oldest outstanding grant
   always @(negedge clk) begin
      if (gnt0 || gnt1) begin
         we_cnt = 0;
         re_cnt = 0;
      end
      if (mem_we_half) we_cnt++;
      if (mem_re_half) re_cnt++;
      if (done0 || done1) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 32'({done1, done0}), 32'h0);
         end else begin
            m_e = sbq.pop_front();
            chk("done_owner", 32'({done1, done0}), m_e.port ? 32'h2 : 32'h1);
            chk("rdata", rdata, m_e.rdata);
            chk("err", 32'(err), 32'(m_e.err));
            chk("latency", 32'(cyc - m_e.gcyc), 32'd2);
            chk("we_strobes", 32'(we_cnt), 32'(m_e.we_n));
            chk("re_strobes", 32'(re_cnt), 32'(m_e.re_n));
         end
      end
   end

   task automatic drain();
      for (int n = 0; n < 10 && sbq.size() != 0; n++) @(negedge clk);
      if (sbq.size() != 0) begin
         chk("drain_timeout", 32'(sbq.size()), 32'd0);
         sbq.delete();
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // waits for a grant on either port of the round-robin instance
   task automatic wait_gnt(output bit got, output logic port);
      got  = 0;
      port = 0;
      for (int n = 0; n < 10 && !got; n++) begin
         @(negedge clk);
         if (gnt0 || gnt1) begin
            got  = 1;
            port = gnt1;
         end
      end
      if (!got) chk("grant_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_access(input logic p, input logic w, input logic [31:0] a,
                            input logic [31:0] d, input logic [31:0] er, input logic ee);
      bit   got;
      logic gp;
      @(posedge clk); #1;
      if (!p) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; end
      else    begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; end
      wait_gnt(got, gp);
      if (got) begin
         chk("single_grant_port", 32'(gp), 32'(p));
         push_exp(p, w, a, er, ee);
      end
      @(posedge clk); #1;
      req0 = 0;
      req1 = 0;
      drain();
   endtask

   typedef struct {
      logic        port;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;
   vec_t vt[10];

   initial begin
      bit   got;
      logic gp;
      int   prev;

      vt[0] = '{1'b0, 1'b1, 32'h6,   32'h0000_8001, 32'h0000_0000, 1'b0};
      vt[1] = '{1'b0, 1'b0, 32'h6,   32'h0,         32'hFFFF_8001, 1'b0};
      vt[2] = '{1'b1, 1'b1, 32'h4,   32'h0000_1234, 32'h0000_0000, 1'b0};
      vt[3] = '{1'b1, 1'b0, 32'h4,   32'h0,         32'h0000_1234, 1'b0};
      vt[4] = '{1'b1, 1'b0, 32'h6,   32'h0,         32'hFFFF_8001, 1'b0};
      vt[5] = '{1'b0, 1'b1, 32'h3,   32'h0000_BEEF, 32'h0000_0000, 1'b1};
      vt[6] = '{1'b0, 1'b0, 32'h2,   32'h0,         32'h0000_0000, 1'b0};
      vt[7] = '{1'b1, 1'b0, 32'h5,   32'h0,         32'h0000_0000, 1'b1};
      vt[8] = '{1'b0, 1'b1, 32'h100, 32'hAAAA_7FFF, 32'h0000_0000, 1'b0};
      vt[9] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'h0000_7FFF, 1'b0};

      // reset state, with a request held high during reset
      req0 = 1;
      repeat (2) @(negedge clk);
      chk("rst_gnt0", 32'(gnt0), 32'h0);
      chk("rst_done", 32'({done1, done0}), 32'h0);
      chk("rst_err", 32'(err), 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_strobes", 32'({mem_we_half, mem_re_half}), 32'h0);
      @(posedge clk); #1;
      req0 = 0;
      rst  = 0;

      for (int i = 0; i < 10; i++)
         do_access(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rdata, vt[i].exp_err);

      // round-robin with both ports held: 0,1,0,1 three cycles apart
      do_reset();
      @(negedge clk);
      chk("rst2_rdata", rdata, 32'h0);
      chk("rst2_mem_addr", mem_addr, 32'h0);
      @(posedge clk); #1;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h6; addr1 = 32'h6;
      prev = 0;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(got, gp);
         if (got) begin
            chk("rr_order", 32'(gp), 32'(k % 2));
            if (k > 0) chk("rr_spacing", 32'(cyc - prev), 32'd3);
            prev = cyc;
            push_exp(gp, 1'b0, 32'h6, 32'hFFFF_8001, 1'b0);
         end
      end
      @(posedge clk); #1;
      req0 = 0; req1 = 0;
      drain();

      // fixed priority: port 0 wins until it drops its request
      @(posedge clk); #1;
      b_req0 = 1; b_req1 = 1;
      for (int k = 0; k < 4; k++) begin
         got = 0;
         for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (b_gnt0 || b_gnt1) got = 1;
         end
         if (!got) chk("fp_grant_timeout", 32'd0, 32'd1);
         else      chk("fp_order", 32'({b_gnt1, b_gnt0}), (k < 3) ? 32'h1 : 32'h2);
         if (k == 2) begin
            @(posedge clk); #1;
            b_req0 = 0;
         end
      end
      @(posedge clk); #1;
      b_req1 = 0;

      // leave the pointer at port 1, then abort a store with reset in its ACCESS cycle
      do_access(1'b0, 1'b0, 32'h100, 32'h0, 32'h0000_7FFF, 1'b0);
      @(posedge clk); #1;
      req0 = 1; we0 = 1; addr0 = 32'h8; wdata0 = 32'h0000_5555;
      for (int n = 0; n < 10 && !gnt0; n++) @(negedge clk);
      chk("abort_grant", 32'(gnt0), 32'h1);
      @(posedge clk); #1;
      req0 = 0;
      rst  = 1;
      @(negedge clk);
      chk("abort_we_strobe", 32'(mem_we_half), 32'h0);
      chk("abort_gnt", 32'({gnt1, gnt0}), 32'h0);
      @(posedge clk); #1;
      rst = 0;
      for (int n = 0; n < 4; n++) begin
         @(negedge clk);
         chk("abort_no_done", 32'({done1, done0}), 32'h0);
      end
      @(posedge clk); #1;
      req0 = 1; req1 = 1; we0 = 0; we1 = 0; addr0 = 32'h8; addr1 = 32'h8;
      wait_gnt(got, gp);
      if (got) begin
         chk("post_rst_ptr", 32'(gp), 32'h0);
         push_exp(gp, 1'b0, 32'h8, 32'h0, 1'b0);
      end
      @(posedge clk); #1;
      req0 = 0;
      wait_gnt(got, gp);
      if (got) begin
         chk("post_rst_second", 32'(gp), 32'h1);
         push_exp(gp, 1'b0, 32'h8, 32'h0, 1'b0);
      end
      @(posedge clk); #1;
      req1 = 0;
      drain();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
      $fatal(1, "watchdog");
   end

endmodule
